// File: rtl/de0_nano_pio_in_poller.sv
// rtl/de0_nano_pio_in_poller.sv - periodic PIO input poller queueing changed samples for the CPU
// Define PIO_POLL_TIMESTAMP_EN to store a 16-bit cycle stamp with each entry (DATA bits [31:16]).
module de0_nano_pio_in_poller #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  pio_address,
  output logic        pio_read,
  input  logic [31:0] pio_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef PIO_POLL_TIMESTAMP_EN
  localparam int ENT_W = DATA_W + 16;
`else
  localparam int ENT_W = DATA_W;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, ADDR, CAPT} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d, period_q, period_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic               first_q, first_d, ovf_q, ovf_d, irq_q, irq_d;
  logic [DATA_W-1:0]  last_q, last_d, sample;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]   wr_entry;
  logic               go, capt, push, pop, full, push_ok;
  logic               unused_ok;

  assign unused_ok = &{1'b0, pio_readdata, s_writedata};
  assign sample    = pio_readdata[DATA_W-1:0];
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));

`ifdef PIO_POLL_TIMESTAMP_EN
  logic [15:0] ts_q, ts_d;
  assign ts_d     = ts_q + 16'd1;
  assign wr_entry = {ts_q, sample};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_q <= '0;
    else          ts_q <= ts_d;
  end
`else
  assign wr_entry = sample;
`endif

  // Register writes are folded in early so a disabling write aborts the poll on the same edge.
  always_comb begin
    period_d = period_q;
    ctrl_d   = ctrl_q;
    if (s_write && s_address == 2'd2) period_d = s_writedata[DIV_W-1:0];
    if (s_write && s_address == 2'd3) ctrl_d   = s_writedata[1:0];
    go = ctrl_d[0] && (period_d != '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!go) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin state_d = WAIT; cnt_d = period_d; end
        WAIT: begin
          if (cnt_q == DIV_W'(1)) state_d = ADDR;
          else                    cnt_d   = cnt_q - DIV_W'(1);
        end
        ADDR:    state_d = CAPT;
        CAPT:    begin state_d = WAIT; cnt_d = period_d; end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pio_read    = (state_q == ADDR);
    pio_address = 2'b00;
    s_readdata  = rdata_q;
    irq         = irq_q;
  end

  always_comb begin
    capt    = (state_q == CAPT) && go;
    first_d = first_q;
    last_d  = last_q;
    push    = 1'b0;
    if (state_q == IDLE) first_d = 1'b1;
    if (capt) begin
      first_d = 1'b0;
      last_d  = sample;
      push    = !first_q && (sample != last_q);
    end
    pop      = s_read && (s_address == 2'd0) && (count_q != '0);
    push_ok  = push && (!full || pop);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    ovf_d    = ovf_q;
    if (s_write && s_address == 2'd1 && s_writedata[10]) ovf_d = 1'b0;
    if (push && full && !pop) ovf_d = 1'b1;
    irq_d = ctrl_d[1] && ((count_d != '0) || ovf_d);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (s_read) begin
      rdata_d = '0;
      case (s_address)
        2'd0: if (count_q != '0) begin
          rdata_d[15]         = 1'b1;
          rdata_d[DATA_W-1:0] = mem_q[rd_ptr_q][DATA_W-1:0];
`ifdef PIO_POLL_TIMESTAMP_EN
          rdata_d[31:16]      = mem_q[rd_ptr_q][ENT_W-1:DATA_W];
`endif
        end
        2'd1: begin
          rdata_d[7:0] = 8'(count_q);
          rdata_d[8]   = (count_q == '0);
          rdata_d[9]   = full;
          rdata_d[10]  = ovf_q;
        end
        2'd2:    rdata_d[DIV_W-1:0] = period_q;
        default: rdata_d[1:0]       = ctrl_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      ctrl_q   <= '0;
      first_q  <= 1'b1;
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      ctrl_q   <= ctrl_d;
      first_q  <= first_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_entry;
  end
endmodule

// File: tb/tb_de0_nano_pio_in_poller.sv
// tb/tb_de0_nano_pio_in_poller.sv - directed bench with a schedule-level poller model
module tb_de0_nano_pio_in_poller;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  pio_address;
  logic        pio_read;
  logic [31:0] pio_q = '0;
  logic [1:0]  s_address = '0;
  logic        s_read = 1'b0, s_write = 1'b0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic        irq;
  logic [7:0]  in_port = '0;
  int          checks = 0, failures = 0, cyc = 0;

  de0_nano_pio_in_poller dut (
    .clk(clk), .reset_n(reset_n), .pio_address(pio_address), .pio_read(pio_read),
    .pio_readdata(pio_q), .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_readdata(s_readdata), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin cyc++; pio_q <= {24'b0, in_port}; end

  // Model: a poll is a capture edge every PERIOD+2 edges after enabling, nothing more.
  logic [31:0] mq[$];
  logic [15:0] m_period, m_ts;
  logic [1:0]  m_ctrl;
  logic        m_ovf, m_irq, m_run, m_first;
  logic [7:0]  m_last;
  logic [31:0] m_rdata;
  int          m_left;

  always @(posedge clk or negedge reset_n) begin
    logic [15:0] pn;
    logic [1:0]  cn;
    logic        go, pop, cap, push;
    logic [7:0]  smp;
    logic [31:0] ent;
    int          sz;
    if (!reset_n) begin
      mq.delete(); m_period = 0; m_ctrl = 0; m_ovf = 0; m_irq = 0; m_rdata = 0;
      m_run = 0; m_left = 0; m_first = 1; m_last = 0; m_ts = 0;
    end else begin
      pn = m_period; cn = m_ctrl;
      if (s_write && s_address == 2'd2) pn = s_writedata[15:0];
      if (s_write && s_address == 2'd3) cn = s_writedata[1:0];
      go  = cn[0] && pn != 0;
      sz  = mq.size();
      pop = s_read && s_address == 2'd0 && sz > 0;
      if (s_read) begin
        case (s_address)
          2'd0: m_rdata = (sz > 0) ? (mq[0] | 32'h8000) : 32'h0;
          2'd1: m_rdata = 32'(sz) | ((sz == 0) ? 32'h100 : 0) | ((sz == 4) ? 32'h200 : 0)
                          | (m_ovf ? 32'h400 : 0);
          2'd2: m_rdata = {16'b0, m_period};
          default: m_rdata = {30'b0, m_ctrl};
        endcase
      end
      smp = pio_q[7:0];
`ifdef PIO_POLL_TIMESTAMP_EN
      ent = {m_ts, 8'h0, smp};
`else
      ent = {24'h0, smp};
`endif
      cap  = m_run && m_left == 1 && go;
      push = cap && !m_first && smp != m_last;
      if (pop) void'(mq.pop_front());
      if (s_write && s_address == 2'd1 && s_writedata[10]) m_ovf = 0;
      if (push) begin
        if (sz < 4 || pop) mq.push_back(ent);
        else m_ovf = 1;
      end
      if (!go) m_run = 0;
      else if (!m_run) begin m_run = 1; m_left = pn + 2; m_first = 1; end
      else if (cap) begin m_left = pn + 2; m_first = 0; m_last = smp; end
      else m_left--;
      m_ts = m_ts + 16'd1;
      m_period = pn; m_ctrl = cn;
      m_irq = cn[1] && (mq.size() > 0 || m_ovf);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
    chk("pio_read", {31'b0, pio_read}, {31'b0, (m_run && m_left == 2)});
    chk("pio_address", {30'b0, pio_address}, 32'h0);
    chk("s_readdata", s_readdata, m_rdata);
  end

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk); s_read = 1'b1; s_address = a;
    @(negedge clk); s_read = 1'b0; d = s_readdata;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(name, d & 32'hFFFF, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); s_write = 1'b1; s_address = a; s_writedata = d;
    @(negedge clk); s_write = 1'b0;
  endtask

  task automatic wait_addr();
    int n = 0;
    while (pio_read && n < 200) begin @(negedge clk); n++; end
    while (!pio_read && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL wait_addr timeout actual=no_pio_read required=pio_read_pulse");
    end
  endtask

  task automatic next_val(input logic [7:0] v);
    wait_addr(); in_port = v; @(negedge clk);
  endtask

  initial begin
    logic [31:0] a, b;
    int c1;
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    int c1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("reset_irq", {31'b0, irq}, 32'h0);
    rd_chk("reset_data", 2'd0, 32'h0);
    rd_chk("reset_status", 2'd1, 32'h100);
    rd_chk("reset_period", 2'd2, 32'h0);
    rd_chk("reset_control", 2'd3, 32'h0);

    in_port = 8'h5A;
    wr(2'd2, 32'd4); wr(2'd3, 32'd3);
    wait_addr(); c1 = cyc; wait_addr();
    chk("poll_gap", 32'(cyc - c1), 32'd6);
    repeat (8) @(negedge clk);
    rd_chk("steady_status", 2'd1, 32'h100);
    in_port = 8'hA5;
    repeat (14) @(negedge clk);
    rd_chk("change_status", 2'd1, 32'h001);
    chk("change_irq", {31'b0, irq}, 32'h1);
    rd_chk("change_data", 2'd0, 32'h80A5);
    rd_chk("after_pop_status", 2'd1, 32'h100);
    chk("after_pop_irq", {31'b0, irq}, 32'h0);

    for (int i = 1; i <= 5; i++) next_val(8'(i));
    repeat (3) @(negedge clk);
    rd_chk("ovf_status", 2'd1, 32'h604);
    for (int i = 1; i <= 4; i++) rd_chk("ovf_pop", 2'd0, 32'h8000 | 32'(i));
    rd_chk("ovf_empty_status", 2'd1, 32'h500);
    chk("ovf_irq", {31'b0, irq}, 32'h1);
    wr(2'd1, 32'h400);
    chk("ovf_clr_irq", {31'b0, irq}, 32'h0);
    rd_chk("ovf_clr_status", 2'd1, 32'h100);

    for (int i = 0; i < 4; i++) next_val(8'h11 + 8'(i));
    repeat (3) @(negedge clk);
    rd_chk("full_status", 2'd1, 32'h204);
    wait_addr(); in_port = 8'h15;
    @(negedge clk); s_read = 1'b1; s_address = 2'd0;
    @(negedge clk); s_read = 1'b0;
    chk("pushpop_data", s_readdata & 32'hFFFF, 32'h8011);
    rd_chk("pushpop_status", 2'd1, 32'h204);
    for (int i = 2; i <= 5; i++) rd_chk("pushpop_order", 2'd0, 32'h8010 | 32'(i));

    next_val(8'h21);
    repeat (2) @(negedge clk);
    in_port = 8'h22;
    wr(2'd3, 32'd0);
    repeat (20) @(negedge clk);
    rd_chk("dis_wait_status", 2'd1, 32'h001);
    wr(2'd3, 32'd3);
    wait_addr(); repeat (2) @(negedge clk);
    rd_chk("reenable_status", 2'd1, 32'h001);
    wait_addr(); in_port = 8'h23;
    @(negedge clk); s_write = 1'b1; s_address = 2'd3; s_writedata = 32'd0;
    @(negedge clk); s_write = 1'b0;
    repeat (10) @(negedge clk);
    rd_chk("dis_capt_status", 2'd1, 32'h001);

    wr(2'd3, 32'd3);
    wait_addr(); repeat (3) @(negedge clk);
    chk("pre_reset_irq", {31'b0, irq}, 32'h1);
    reset_n = 1'b0; #1;
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_pio_read", {31'b0, pio_read}, 32'h0);
    chk("rst_readdata", s_readdata, 32'h0);
    @(negedge clk); reset_n = 1'b1;
    rd_chk("rst_status", 2'd1, 32'h100);
    rd_chk("rst_control", 2'd3, 32'h0);

`ifdef PIO_POLL_TIMESTAMP_EN
    in_port = 8'h30;
    wr(2'd2, 32'd10); wr(2'd3, 32'd1);
    wait_addr();
    next_val(8'h31);
    wait_addr(); wait_addr();
    next_val(8'h32);
    repeat (3) @(negedge clk);
    rd(2'd0, a); rd(2'd0, b);
    chk("ts_data_a", a & 32'hFFFF, 32'h8031);
    chk("ts_data_b", b & 32'hFFFF, 32'h8032);
    chk("ts_delta", 32'(16'(b[31:16] - a[31:16])), 32'd36);
`endif

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
